mixer_scheduler: RTL and testbench



---
 rtl/mixer_sched_pkg.sv | 50 +++++
 rtl/mixer_scheduler_checker.sv | 29 ++
 rtl/rr_arbiter.sv | 70 +++++++
 rtl/mixer_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_mixer_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mixer_sched_pkg.sv
// ---------------------------------------------------------------------------
// mixer_sched_pkg
// Shared types and constants for the mixer chamber scheduler:
//   state_t      - job sequencing FSM states
//   PUMP_TABLE   - six 3-bit peristaltic valve patterns (phase 0 in bits [2:0])
//   LAST_PHASE   - index of the final pump phase in one round
//   pump_pattern - valve pattern for a given pump phase index
//   next_phase   - phase index that follows a given phase (wraps 5 -> 0)
// ---------------------------------------------------------------------------
package mixer_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_GAP1  = 3'd2,
    ST_MIX   = 3'd3,
    ST_GAP2  = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Peristaltic sequence 100,110,010,011,001,101; phase 0 sits in the low bits.
  localparam logic [17:0] PUMP_TABLE = {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
  localparam logic [2:0]  LAST_PHASE = 3'd5;

  function automatic logic [2:0] pump_pattern(input logic [2:0] phase);
    logic [2:0] pat;
    case (phase)
      3'd0:    pat = PUMP_TABLE[2:0];
      3'd1:    pat = PUMP_TABLE[5:3];
      3'd2:    pat = PUMP_TABLE[8:6];
      3'd3:    pat = PUMP_TABLE[11:9];
      3'd4:    pat = PUMP_TABLE[14:12];
      3'd5:    pat = PUMP_TABLE[17:15];
      default: pat = 3'b000;
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] phase);
    logic [2:0] nxt;
    if (phase >= LAST_PHASE) begin
      nxt = 3'd0;
    end else begin
      nxt = phase + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mixer_scheduler_checker.sv
// ---------------------------------------------------------------------------
// mixer_scheduler_checker
// Safety invariants on the valve outputs of mixer_scheduler.
// Ports: clk, rst_n, busy, inlet_open, pump, flush_open, outlet_open
//   (all inputs, connected to the matching scheduler signals).
// ---------------------------------------------------------------------------
module mixer_scheduler_checker #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic               busy,
  input logic [NUM_REQ-1:0] inlet_open,
  input logic [2:0]         pump,
  input logic               flush_open,
  input logic               outlet_open
);

  a_one_inlet : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(inlet_open));

  a_no_inlet_with_drain : assert property (@(posedge clk) disable iff (!rst_n)
    !((|inlet_open) && (flush_open || outlet_open)));

  // Pump motion only while mixing: nothing else open and a job is active.
  a_pump_only_mixing : assert property (@(posedge clk) disable iff (!rst_n)
    (pump != 3'b000) |-> (busy && (inlet_open == '0) && !flush_open && !outlet_open));

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin picker over NUM_REQ level requests. Owns the pointer register;
// the pointer moves to (picked index + 1) mod NUM_REQ when update is strobed.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointer -> 0)
//   req          request vector
//   update       advance the pointer past the current pick
//   pick         one-hot first asserted request at or after the pointer
//   valid        at least one request asserted
// ---------------------------------------------------------------------------
module rr_arbiter
  import mixer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] idx_s;
  logic [PW-1:0] pos_s;
  logic          found_s;
  logic          hit_s;

  // Scan from the pointer, wrapping, and take the first asserted request.
  always_comb begin
    pick    = '0;
    idx_s   = '0;
    pos_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos_s = PW'((int'(ptr_r) + i) % NUM_REQ);
      hit_s = req[pos_s] & ~found_s;
      if (hit_s) begin
        pick[pos_s] = 1'b1;
        idx_s       = pos_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid = |req;

  // Pointer register: moves just past the winner when a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (update && found_s) begin
      if (idx_s == PW'(NUM_REQ - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= idx_s + PW'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/mixer_scheduler.sv
// ---------------------------------------------------------------------------
// mixer_scheduler
// Shares one diffusion mixer chamber between NUM_REQ fluid sources and drives
// every pneumatic line around it. Each granted job runs
//   FILL -> GAP1 -> MIX -> GAP2 -> FLUSH -> DONE -> IDLE
// with a one-cycle all-closed gap between wet phases (break-before-make).
// Valve outputs: 1 = vent (open), 0 = pressurised (closed). All outputs are
// registered; req only reaches outputs through the FSM registers.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (all valves close)
//   req           per-source level request, sampled only in IDLE
//   grant         one-hot mixer owner, zero when idle
//   busy          job in progress
//   done          one-cycle pulse in the final job cycle
//   inlet_open    per-source inlet valve
//   pump          3-valve peristaltic pattern
//   flush_open    flush-buffer inlet valve
//   outlet_open   waste outlet valve
//   abort         (MIXER_SCHEDULER_ABORT_EN) cut FILL/GAP1/MIX short, still flush
//   aborted       (MIXER_SCHEDULER_ABORT_EN) high with done for an aborted job
// Optional feature macro: MIXER_SCHEDULER_ABORT_EN.
// ---------------------------------------------------------------------------
module mixer_scheduler
  import mixer_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int FILL_CYC       = 16,
  parameter int PUMP_PHASE_CYC = 4,
  parameter int MIX_ROUNDS     = 8,
  parameter int FLUSH_CYC      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done,
  output logic [NUM_REQ-1:0] inlet_open,
  output logic [2:0]         pump,
  output logic               flush_open,
  output logic               outlet_open
`ifdef MIXER_SCHEDULER_ABORT_EN
  ,
  input  logic               abort,
  output logic               aborted
`endif
);

  // Counters only ever hold (length - 1) down to zero.
  localparam int MAX_A   = (FILL_CYC > FLUSH_CYC) ? FILL_CYC : FLUSH_CYC;
  localparam int MAX_B   = (PUMP_PHASE_CYC > MIX_ROUNDS) ? PUMP_PHASE_CYC : MIX_ROUNDS;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] FILL_LOAD  = CW'(FILL_CYC - 1);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(PUMP_PHASE_CYC - 1);
  localparam logic [CW-1:0] ROUND_LOAD = CW'(MIX_ROUNDS - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYC - 1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] round_r;
  logic [2:0]    phase_r;

  logic [NUM_REQ-1:0] arb_pick_s;
  logic               arb_valid_s;
  logic               arb_update_s;
  logic               abort_hit_s;

  // The pointer advances exactly on the edge a new job is accepted.
  assign arb_update_s = (state_r == ST_IDLE) && arb_valid_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (arb_update_s),
    .pick   (arb_pick_s),
    .valid  (arb_valid_s)
  );

`ifdef MIXER_SCHEDULER_ABORT_EN
  logic abort_flag_r;

  // Abort only shortens the wet phases before the rinse; it never skips FLUSH.
  assign abort_hit_s = abort && ((state_r == ST_FILL) || (state_r == ST_GAP1) ||
                                 (state_r == ST_MIX));

  // Remember an abort for the job and present it alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_flag_r <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      if (abort_hit_s) begin
        abort_flag_r <= 1'b1;
      end else if (state_r == ST_DONE) begin
        abort_flag_r <= 1'b0;
      end else begin
        abort_flag_r <= abort_flag_r;
      end
      aborted <= (state_r == ST_FLUSH) && (cnt_r == '0) && abort_flag_r;
    end
  end
`else
  assign abort_hit_s = 1'b0;
`endif

  // Job sequencer: owns state, phase/round counters and every valve output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      round_r     <= '0;
      phase_r     <= 3'd0;
      grant       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      inlet_open  <= '0;
      pump        <= 3'b000;
      flush_open  <= 1'b0;
      outlet_open <= 1'b0;
    end else if (abort_hit_s) begin
      // Close everything wet and go straight to the pre-flush gap.
      state_r    <= ST_GAP2;
      cnt_r      <= '0;
      round_r    <= '0;
      phase_r    <= 3'd0;
      inlet_open <= '0;
      pump       <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            grant      <= arb_pick_s;
            inlet_open <= arb_pick_s;
            busy       <= 1'b1;
            cnt_r      <= FILL_LOAD;
            state_r    <= ST_FILL;
          end else begin
            grant <= '0;
          end
        end
        ST_FILL: begin
          if (cnt_r == '0) begin
            inlet_open <= '0;
            state_r    <= ST_GAP1;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_GAP1: begin
          phase_r <= 3'd0;
          pump    <= pump_pattern(3'd0);
          cnt_r   <= PHASE_LOAD;
          round_r <= ROUND_LOAD;
          state_r <= ST_MIX;
        end
        ST_MIX: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
          end else if (phase_r != LAST_PHASE) begin
            phase_r <= next_phase(phase_r);
            pump    <= pump_pattern(next_phase(phase_r));
            cnt_r   <= PHASE_LOAD;
          end else if (round_r != '0) begin
            round_r <= round_r - CW'(1);
            phase_r <= 3'd0;
            pump    <= pump_pattern(3'd0);
            cnt_r   <= PHASE_LOAD;
          end else begin
            pump    <= 3'b000;
            state_r <= ST_GAP2;
          end
        end
        ST_GAP2: begin
          flush_open  <= 1'b1;
          outlet_open <= 1'b1;
          cnt_r       <= FLUSH_LOAD;
          state_r     <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (cnt_r == '0) begin
            flush_open  <= 1'b0;
            outlet_open <= 1'b0;
            done        <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_DONE: begin
          grant   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          round_r     <= '0;
          phase_r     <= 3'd0;
          grant       <= '0;
          busy        <= 1'b0;
          done        <= 1'b0;
          inlet_open  <= '0;
          pump        <= 3'b000;
          flush_open  <= 1'b0;
          outlet_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mixer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mixer_scheduler
// Scoreboard bench: expected per-cycle output vectors are queued when a
// request is driven and popped against the DUT on every falling edge.
// Vector layout: {aborted, grant[3:0], busy, done, inlet[3:0], pump[2:0],
//                 flush_open, outlet_open}.
// ---------------------------------------------------------------------------
module tb_mixer_scheduler;

  localparam int NR  = 4;
  localparam int FC  = 2;
  localparam int PPC = 1;
  localparam int MR  = 1;
  localparam int FLC = 2;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0] grant;
  logic          busy;
  logic          done;
  logic [NR-1:0] inlet_open;
  logic [2:0]    pump;
  logic          flush_open;
  logic          outlet_open;
  logic          aborted;
`ifdef MIXER_SCHEDULER_ABORT_EN
  logic          abort;
`else
  assign aborted = 1'b0;
`endif

  int n_cmp;
  int n_err;
  logic [15:0] exp_q[$];
  logic [2:0]  pump_seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  mixer_scheduler #(
    .NUM_REQ        (NR),
    .FILL_CYC       (FC),
    .PUMP_PHASE_CYC (PPC),
    .MIX_ROUNDS     (MR),
    .FLUSH_CYC      (FLC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .inlet_open  (inlet_open),
    .pump        (pump),
    .flush_open  (flush_open),
    .outlet_open (outlet_open)
`ifdef MIXER_SCHEDULER_ABORT_EN
    ,
    .abort       (abort),
    .aborted     (aborted)
`endif
  );

  mixer_scheduler_checker #(.NUM_REQ(NR)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (busy),
    .inlet_open  (inlet_open),
    .pump        (pump),
    .flush_open  (flush_open),
    .outlet_open (outlet_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] g, input logic b, input logic d,
                                     input logic [3:0] inl, input logic [2:0] p,
                                     input logic f, input logic o, input logic a);
    return {a, g, b, d, inl, p, f, o};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {aborted, grant, busy, done, inlet_open, pump, flush_open, outlet_open};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the first n cycles of a full job for source src.
  task automatic push_job(input int src, input int n);
    logic [15:0] seq[$];
    logic [3:0]  oh;
    oh = 4'(1 << src);
    for (int i = 0; i < FC; i++) seq.push_back(mk(oh, 1'b1, 1'b0, oh, 3'b000, 1'b0, 1'b0, 1'b0));
    seq.push_back(mk(oh, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0));
    for (int r = 0; r < MR; r++)
      for (int p = 0; p < 6; p++)
        for (int c = 0; c < PPC; c++)
          seq.push_back(mk(oh, 1'b1, 1'b0, 4'b0000, pump_seq[p], 1'b0, 1'b0, 1'b0));
    seq.push_back(mk(oh, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < FLC; i++) seq.push_back(mk(oh, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b1, 1'b1, 1'b0));
    seq.push_back(mk(oh, 1'b1, 1'b1, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < n && i < seq.size(); i++) exp_q.push_back(seq[i]);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'h0000);
  endtask

  // Pop and compare one expected vector per falling edge.
  task automatic run_cycles(input string tag, input int n);
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check_val({tag, "_queue_underrun"}, 32'(obs_vec()), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("%s_c%0d", tag, i), 32'(obs_vec()), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
`ifdef MIXER_SCHEDULER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_val("reset_outputs", 32'(obs_vec()), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
`ifdef MIXER_SCHEDULER_ABORT_EN
    abort = 1'b0;
`endif

    // Single one-cycle request from source 0: 13 busy cycles then idle.
    do_reset();
    req = 4'b0001;
    push_job(0, 13); push_idle(1);
    run_cycles("single", 1);
    req = '0;
    run_cycles("single", 13);

    // All sources held: 0,1,2,3,0 with one idle cycle between jobs.
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      push_job(s, 13); push_idle(1);
    end
    push_job(0, 13); push_idle(1);
    run_cycles("rr", 4 * 14 + 1);
    req = '0;
    run_cycles("rr", 13);

    // Serve source 2 (pointer -> 3), then 0011 must wrap to source 0, then 1.
    do_reset();
    req = 4'b0100;
    push_job(2, 13); push_idle(1);
    run_cycles("wrap_pre", 1);
    req = '0;
    run_cycles("wrap_pre", 13);
    req = 4'b0011;
    push_job(0, 13); push_idle(1); push_job(1, 13); push_idle(1);
    run_cycles("wrap", 15);
    req = '0;
    run_cycles("wrap", 13);

    // Request dropped during MIX: job completes and no second grant follows.
    req = 4'b1000;
    push_job(3, 13); push_idle(3);
    run_cycles("drop", 5);
    req = '0;
    run_cycles("drop", 11);

    // Reset in FLUSH closes everything at once; pointer returns to 0 so
    // source 0 beats source 2 afterwards.
    req = 4'b0001;
    push_job(0, 11);
    run_cycles("rst_mid", 1);
    req = '0;
    run_cycles("rst_mid", 10);
    #2 rst_n = 1'b0;
    #1 check_val("async_reset_outputs", 32'(obs_vec()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0101;
    push_job(0, 13); push_idle(1);
    run_cycles("post_rst", 1);
    req = '0;
    run_cycles("post_rst", 13);

`ifdef MIXER_SCHEDULER_ABORT_EN
    // Abort during the third pump phase: gap, 2 flush cycles, done+aborted.
    req = 4'b0001;
    push_job(0, 3 + 3);
    exp_q.push_back(mk(4'b0001, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < FLC; i++) exp_q.push_back(mk(4'b0001, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(4'b0001, 1'b1, 1'b1, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1));
    push_idle(1);
    run_cycles("abort", 1);
    req = '0;
    run_cycles("abort", 5);
    abort = 1'b1;
    run_cycles("abort", 1);
    abort = 1'b0;
    run_cycles("abort", 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
